// File: rtl/clock_pkg.sv
// Shared encodings for the clock's time-setting path: mode/position codes and digit blank pairs.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL    = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_e;

    localparam logic [5:0] MASK_SEC  = 6'b000011;
    localparam logic [5:0] MASK_MIN  = 6'b001100;
    localparam logic [5:0] MASK_HOUR = 6'b110000;

    function automatic logic [5:0] pos_mask(input pos_e p);
        logic [5:0] m;
        case (p)
            POS_SEC:  m = MASK_SEC;
            POS_MIN:  m = MASK_MIN;
            POS_HOUR: m = MASK_HOUR;
            default:  m = 6'b000000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/blink_phase_gen.sv
// Blink half-period counter and ON/OFF toggle for the digit being set.
// phase is the lookahead value (what the toggle holds after the coming edge), 1 = ON.
module blink_phase_gen #(
    parameter int BLINK_DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic phase
);

    localparam int CW = $clog2(BLINK_DIV);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_phase;
    logic          w_phase_nxt;

    always_comb begin
        w_cnt_nxt   = r_cnt + CW'(1);
        w_phase_nxt = r_phase;
        if (!enable || restart) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b1;
        end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = ~r_phase;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Exposed ahead of the register so the caller's mask register lines up with mode/position.
    assign phase = w_phase_nxt;

endmodule

// File: rtl/setting_ctrl.sv
// Time-setting sequencer: mode/position FSM, increment strobes and blinking digit masks.
// Optional idle auto-return to NORMAL is built when SETTING_TIMEOUT_EN is defined.
module setting_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_DIV      = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_mode,
    input  logic       sw_pos,
    input  logic       sw_inc,
    output logic [1:0] setting_mode,
    output logic [1:0] setting_position,
    output logic [5:0] blank_mask,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hour
);

    mode_e      r_mode;
    mode_e      w_mode_nxt;
    pos_e       r_pos;
    pos_e       w_pos_nxt;
    logic [2:0] r_inc;
    logic [2:0] w_inc_nxt;
    logic [5:0] r_mask;
    logic       w_in_set;
    logic       w_set_nxt;
    logic       w_accept;
    logic       w_restart;
    logic       w_timeout;
    logic       w_phase;

    assign w_in_set  = (r_mode != MODE_NORMAL);
    assign w_accept  = sw_mode | (w_in_set & (sw_pos | sw_inc));
    assign w_set_nxt = (w_mode_nxt != MODE_NORMAL);

`ifdef SETTING_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    logic [IW-1:0] r_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (!w_set_nxt || w_accept) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + IW'(1);
        end
    end

    assign w_timeout = w_in_set && (r_idle == IW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Priority sw_mode > sw_pos > sw_inc > timeout; lower-priority events in the same cycle are dropped.
    always_comb begin
        w_mode_nxt = r_mode;
        w_pos_nxt  = r_pos;
        w_inc_nxt  = 3'b000;
        w_restart  = 1'b0;
        if (sw_mode) begin
            case (r_mode)
                MODE_NORMAL:   w_mode_nxt = MODE_SET_TIME;
                MODE_SET_TIME: w_mode_nxt = MODE_SET_ALARM;
                default:       w_mode_nxt = MODE_NORMAL;
            endcase
            w_pos_nxt = POS_SEC;
            w_restart = 1'b1;
        end else if (w_in_set && sw_pos) begin
            case (r_pos)
                POS_SEC: w_pos_nxt = POS_MIN;
                POS_MIN: w_pos_nxt = POS_HOUR;
                default: w_pos_nxt = POS_SEC;
            endcase
        end else if (w_in_set && sw_inc) begin
            w_restart = 1'b1;
            case (r_pos)
                POS_SEC: w_inc_nxt = 3'b001;
                POS_MIN: w_inc_nxt = 3'b010;
                default: w_inc_nxt = 3'b100;
            endcase
        end else if (w_timeout) begin
            w_mode_nxt = MODE_NORMAL;
            w_pos_nxt  = POS_SEC;
        end
    end

    blink_phase_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_set_nxt),
        .restart (w_restart),
        .phase   (w_phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_NORMAL;
            r_pos  <= POS_SEC;
            r_inc  <= 3'b000;
            r_mask <= 6'b000000;
        end else begin
            r_mode <= w_mode_nxt;
            r_pos  <= w_pos_nxt;
            r_inc  <= w_inc_nxt;
            r_mask <= (w_set_nxt && !w_phase) ? pos_mask(w_pos_nxt) : 6'b000000;
        end
    end

    assign setting_mode     = r_mode;
    assign setting_position = r_pos;
    assign blank_mask       = r_mask;
    assign inc_sec          = r_inc[0];
    assign inc_min          = r_inc[1];
    assign inc_hour         = r_inc[2];

endmodule

// File: tb/tb_setting_ctrl.sv
// Scoreboard bench for setting_ctrl: stimulus queues hand-computed per-cycle expectations, a monitor pops and compares.
module tb_setting_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_mode = 1'b0;
    logic       sw_pos = 1'b0;
    logic       sw_inc = 1'b0;
    logic [1:0] setting_mode;
    logic [1:0] setting_position;
    logic [5:0] blank_mask;
    logic       inc_sec;
    logic       inc_min;
    logic       inc_hour;

    setting_ctrl #(
        .BLINK_DIV      (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sw_mode          (sw_mode),
        .sw_pos           (sw_pos),
        .sw_inc           (sw_inc),
        .setting_mode     (setting_mode),
        .setting_position (setting_position),
        .blank_mask       (blank_mask),
        .inc_sec          (inc_sec),
        .inc_min          (inc_min),
        .inc_hour         (inc_hour)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] m;
        logic [1:0] p;
        logic [5:0] k;
        logic [2:0] s;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_at(input int c, input logic [1:0] m, input logic [1:0] p,
                             input logic [5:0] k, input logic [2:0] s, input string tag);
        exp_t e;
        e.cyc = c; e.m = m; e.p = p; e.k = k; e.s = s; e.tag = tag;
        q.push_back(e);
    endtask

    // strobes compared as {inc_hour, inc_min, inc_sec}
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] s_got;
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            s_got = {inc_hour, inc_min, inc_sec};
            n_cmp++;
            if (e.cyc != cyc || setting_mode !== e.m || setting_position !== e.p ||
                blank_mask !== e.k || s_got !== e.s) begin
                n_bad++;
                $display("FAIL %s cyc=%0d(want %0d): got mode=%0d pos=%0d mask=%b inc=%b, required mode=%0d pos=%0d mask=%b inc=%b",
                         e.tag, cyc, e.cyc, setting_mode, setting_position, blank_mask, s_got,
                         e.m, e.p, e.k, e.s);
            end
        end
    end

    task automatic tick(input logic m, input logic p, input logic i);
        sw_mode = m; sw_pos = p; sw_inc = i;
        @(posedge clk);
        #2;
        sw_mode = 1'b0; sw_pos = 1'b0; sw_inc = 1'b0;
    endtask

    int b;
    int E;

    initial begin
        // reset state while rst held, then after release
        expect_at(1, 0, 0, 6'd0, 3'b000, "reset_hold1");
        expect_at(2, 0, 0, 6'd0, 3'b000, "reset_hold2");
        tick(0, 0, 0);
        tick(0, 0, 0);
        rst = 1'b0;
        b = cyc;
        expect_at(b + 1, 0, 0, 6'd0, 3'b000, "post_reset_inc_ignored");
        tick(0, 0, 1);

        // mode cycling with blink of sec pair
        b = cyc;
        expect_at(b + 1,  1, 0, 6'd0,  3'b000, "enter_set_time");
        expect_at(b + 4,  1, 0, 6'd0,  3'b000, "blink_on_last");
        expect_at(b + 5,  1, 0, 6'd3,  3'b000, "blink_off_sec");
        expect_at(b + 8,  1, 0, 6'd3,  3'b000, "blink_off_last");
        expect_at(b + 9,  1, 0, 6'd0,  3'b000, "blink_on_again");
        expect_at(b + 11, 2, 0, 6'd0,  3'b000, "enter_set_alarm");
        expect_at(b + 15, 2, 0, 6'd3,  3'b000, "alarm_blink_off");
        expect_at(b + 21, 0, 0, 6'd0,  3'b000, "back_to_normal");
        for (int k = 1; k <= 21; k++) tick(k == 1 || k == 11 || k == 21, 0, 0);

        // sw_pos ignored in NORMAL, then min pair blinking
        b = cyc;
        expect_at(b + 1,  0, 0, 6'd0,  3'b000, "pos_ignored_normal");
        expect_at(b + 3,  1, 1, 6'd0,  3'b000, "pos_to_min");
        expect_at(b + 5,  1, 1, 6'd0,  3'b000, "min_on_last");
        expect_at(b + 6,  1, 1, 6'd12, 3'b000, "min_off");
        expect_at(b + 9,  1, 1, 6'd12, 3'b000, "min_off_last");
        expect_at(b + 10, 1, 1, 6'd0,  3'b000, "min_on_again");
        expect_at(b + 14, 1, 1, 6'd12, 3'b000, "min_off_again");
        for (int k = 1; k <= 14; k++) tick(k == 2, k == 1 || k == 3, 0);

        // position change mid-OFF, hour increments, back-to-back, wrap to sec, min strobe
        b = cyc;
        expect_at(b + 1,  1, 2, 6'd48, 3'b000, "pos_hour_mid_off");
        expect_at(b + 2,  1, 2, 6'd0,  3'b100, "inc_hour");
        expect_at(b + 3,  1, 2, 6'd0,  3'b000, "inc_hour_single");
        expect_at(b + 5,  1, 2, 6'd0,  3'b000, "inc_restart_on");
        expect_at(b + 6,  1, 2, 6'd48, 3'b000, "hour_off");
        expect_at(b + 7,  1, 2, 6'd0,  3'b100, "inc_hour_b2b_1");
        expect_at(b + 8,  1, 2, 6'd0,  3'b100, "inc_hour_b2b_2");
        expect_at(b + 9,  1, 2, 6'd0,  3'b000, "inc_hour_b2b_end");
        expect_at(b + 10, 1, 0, 6'd0,  3'b000, "pos_wrap_sec");
        expect_at(b + 11, 1, 0, 6'd0,  3'b001, "inc_sec");
        expect_at(b + 13, 1, 1, 6'd0,  3'b010, "inc_min");
        for (int k = 1; k <= 13; k++)
            tick(0, k == 1 || k == 10 || k == 12, k == 2 || k == 7 || k == 8 || k == 11 || k == 13);

        // simultaneous pulses: mode wins, nothing else
        b = cyc;
        expect_at(b + 1, 2, 0, 6'd0, 3'b000, "all_three_pulses");
        expect_at(b + 2, 2, 0, 6'd0, 3'b000, "all_three_after");
        tick(1, 1, 1);
        tick(0, 0, 0);

        // idle behaviour in SET_ALARM
        b = cyc;
        E = b + 3;
        expect_at(b + 1,  0, 0, 6'd0,  3'b000, "alarm_to_normal");
        expect_at(b + 2,  1, 0, 6'd0,  3'b000, "normal_to_time");
        expect_at(E,      2, 0, 6'd0,  3'b000, "time_to_alarm");
        expect_at(E + 19, 2, 0, 6'd0,  3'b000, "idle19_no_timeout");
        expect_at(E + 20, 2, 1, 6'd12, 3'b000, "pos_at_idle19_keeps_mode");
`ifdef SETTING_TIMEOUT_EN
        expect_at(E + 39, 2, 1, 6'd12, 3'b000, "idle19_again");
        expect_at(E + 40, 0, 0, 6'd0,  3'b000, "timeout_to_normal");
        expect_at(E + 42, 0, 0, 6'd0,  3'b000, "normal_after_timeout");
        for (int k = 1; k <= 45; k++) tick(k <= 3, k == 23, 0);
`else
        expect_at(E + 40,   2, 1, 6'd0,  3'b000, "no_timeout_40");
        expect_at(E + 1000, 2, 1, 6'd0,  3'b000, "no_timeout_1000");
        expect_at(E + 1004, 2, 1, 6'd12, 3'b000, "still_blinking_1004");
        for (int k = 1; k <= 1008; k++) tick(k <= 3, k == 23, 0);
`endif

        // asynchronous reset in the middle of SET_TIME
        b = cyc;
`ifndef SETTING_TIMEOUT_EN
        expect_at(b + 1, 0, 0, 6'd0, 3'b000, "alarm_to_normal_2");
        tick(1, 0, 0);
        b = cyc;
`endif
        expect_at(b + 1, 1, 0, 6'd0, 3'b000, "reenter_set_time");
        expect_at(b + 2, 1, 1, 6'd0, 3'b000, "pos_before_reset");
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        rst = 1'b1;
        sw_inc = 1'b1;
        expect_at(b + 3, 0, 0, 6'd0, 3'b000, "async_reset_same_cycle");
        expect_at(b + 4, 0, 0, 6'd0, 3'b000, "reset_held_inc");
        expect_at(b + 5, 0, 0, 6'd0, 3'b000, "reset_held_inc2");
        expect_at(b + 6, 0, 0, 6'd0, 3'b000, "release_no_strobe");
        expect_at(b + 7, 0, 0, 6'd0, 3'b000, "after_release");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        sw_inc = 1'b0;
        tick(0, 0, 0);

        for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, required 0", q.size());
            n_bad += q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
